// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one main-memory block port between the I-cache (c0) and D-cache (c1).
// One block transaction in flight at a time, with latched request fields and an ack timeout.
module mem_arbiter #(
    parameter int PA_WIDTH  = 32,
    parameter int MEM_WIDTH = 512,
    parameter int TO_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 c0_req,
    input  logic                 c0_we,
    input  logic [PA_WIDTH-1:0]  c0_addr,
    input  logic [MEM_WIDTH-1:0] c0_wr_blk,
    output logic                 c0_done,
    input  logic                 c1_req,
    input  logic                 c1_we,
    input  logic [PA_WIDTH-1:0]  c1_addr,
    input  logic [MEM_WIDTH-1:0] c1_wr_blk,
    output logic                 c1_done,
    output logic [MEM_WIDTH-1:0] rd_blk,
    output logic                 err,
    output logic                 busy,
    output logic                 owner,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [PA_WIDTH-1:0]  mem_addr,
    output logic [MEM_WIDTH-1:0] mem_wr_blk,
    input  logic                 mem_ack,
    input  logic [MEM_WIDTH-1:0] mem_rd_blk
);

    localparam int CNT_W = $clog2(TO_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TO_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] to_count;
    logic             winner;

    // On a tie the side that was not served last wins, giving strict alternation.
    always_comb begin
        winner = c1_req;
        if (c0_req && c1_req) begin
            winner = ~owner;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            to_count   <= '0;
            owner      <= 1'b1;
            busy       <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wr_blk <= '0;
            rd_blk     <= '0;
            err        <= 1'b0;
            c0_done    <= 1'b0;
            c1_done    <= 1'b0;
        end else begin
            c0_done <= 1'b0;
            c1_done <= 1'b0;
            err     <= 1'b0;
            case (state)
                IDLE: begin
                    if (c0_req || c1_req) begin
                        owner      <= winner;
                        mem_we     <= winner ? c1_we     : c0_we;
                        mem_addr   <= winner ? c1_addr   : c0_addr;
                        mem_wr_blk <= winner ? c1_wr_blk : c0_wr_blk;
                        mem_req    <= 1'b1;
                        busy       <= 1'b1;
                        to_count   <= '0;
                        state      <= BUSY;
                    end
                end
                // An ack in the final wait cycle still counts as success.
                BUSY: begin
                    if (mem_ack || to_count == LAST_WAIT) begin
                        if (mem_ack && !mem_we) begin
                            rd_blk <= mem_rd_blk;
                        end
                        err     <= ~mem_ack;
                        mem_req <= 1'b0;
                        c0_done <= ~owner;
                        c1_done <= owner;
                        state   <= DONE;
                    end else begin
                        to_count <= to_count + 1'b1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected transactions are queued when requests are driven
// and retired against the grant, the memory-side request length and the completion pulse.
module tb_mem_arbiter;

    localparam int PA_WIDTH  = 32;
    localparam int MEM_WIDTH = 512;
    localparam int TO_CYCLES = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 c0_req, c0_we, c1_req, c1_we;
    logic [PA_WIDTH-1:0]  c0_addr, c1_addr;
    logic [MEM_WIDTH-1:0] c0_wr_blk, c1_wr_blk;
    logic                 c0_done, c1_done;
    logic [MEM_WIDTH-1:0] rd_blk;
    logic                 err, busy, owner;
    logic                 mem_req, mem_we;
    logic [PA_WIDTH-1:0]  mem_addr;
    logic [MEM_WIDTH-1:0] mem_wr_blk;
    logic                 mem_ack;
    logic [MEM_WIDTH-1:0] mem_rd_blk;

    mem_arbiter #(
        .PA_WIDTH(PA_WIDTH),
        .MEM_WIDTH(MEM_WIDTH),
        .TO_CYCLES(TO_CYCLES)
    ) dut (
        .clk(clk), .rst(rst),
        .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wr_blk(c0_wr_blk), .c0_done(c0_done),
        .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wr_blk(c1_wr_blk), .c1_done(c1_done),
        .rd_blk(rd_blk), .err(err), .busy(busy), .owner(owner),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wr_blk(mem_wr_blk),
        .mem_ack(mem_ack), .mem_rd_blk(mem_rd_blk)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic                 owner;
        logic                 we;
        logic [PA_WIDTH-1:0]  addr;
        logic [MEM_WIDTH-1:0] wr_blk;
        logic [MEM_WIDTH-1:0] rd_data;
        int                   ack_at;
        int                   req_len;
        logic                 err;
        logic [MEM_WIDTH-1:0] exp_rd;
    } txn_t;

    txn_t                 exp_q[$];
    txn_t                 mon_t;
    int                   checks = 0;
    int                   failures = 0;
    logic [MEM_WIDTH-1:0] model_rd = '0;
    int                   late_ack_req = 0;
    int                   late_ack_done = 0;
    int                   req_cycles = 0;
    logic                 prev_req = 1'b0;

    function automatic logic [MEM_WIDTH-1:0] fill(input logic [7:0] b);
        return {(MEM_WIDTH/8){b}};
    endfunction

    task automatic checkOutput(input string tag, input logic [MEM_WIDTH-1:0] observed,
                               input logic [MEM_WIDTH-1:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // ack_at is the BUSY cycle on which memory acks; 0 or beyond the timeout means never.
    task automatic push_expect(input logic port, input logic we, input logic [PA_WIDTH-1:0] addr,
                               input logic [MEM_WIDTH-1:0] wr_blk, input logic [MEM_WIDTH-1:0] rd_data,
                               input int ack_at);
        txn_t t;
        logic ok;
        ok        = (ack_at >= 1) && (ack_at <= TO_CYCLES);
        t.owner   = port;
        t.we      = we;
        t.addr    = addr;
        t.wr_blk  = wr_blk;
        t.rd_data = rd_data;
        t.ack_at  = ack_at;
        t.req_len = ok ? ack_at : TO_CYCLES;
        t.err     = ~ok;
        if (ok && !we) model_rd = rd_data;
        t.exp_rd  = model_rd;
        exp_q.push_back(t);
    endtask

    task automatic applyStimulus(input logic port, input logic we, input logic [PA_WIDTH-1:0] addr,
                                 input logic [MEM_WIDTH-1:0] wr_blk, input logic [MEM_WIDTH-1:0] rd_data,
                                 input int ack_at);
        push_expect(port, we, addr, wr_blk, rd_data, ack_at);
        if (port) begin
            c1_we = we; c1_addr = addr; c1_wr_blk = wr_blk; c1_req = 1'b1;
        end else begin
            c0_we = we; c0_addr = addr; c0_wr_blk = wr_blk; c0_req = 1'b1;
        end
    endtask

    // Returns on the negedge of the mandatory IDLE cycle that follows a completion.
    task automatic waitDone(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = c0_done || c1_done;
        end
        if (!seen) begin
            checkOutput({tag, "_done_seen"}, 0, 1);
        end else begin
            @(negedge clk);
            checkOutput({tag, "_idle_gap"}, {busy, mem_req}, 2'b00);
        end
    endtask

    // Scoreboard monitor: grant fields against the queue head, completion retires it.
    always @(negedge clk) begin
        if (mem_req && !prev_req && exp_q.size() > 0) begin
            checkOutput("grant_owner", owner, exp_q[0].owner);
            checkOutput("grant_we", mem_we, exp_q[0].we);
            checkOutput("grant_addr", mem_addr, exp_q[0].addr);
            checkOutput("grant_wr_blk", mem_wr_blk, exp_q[0].wr_blk);
        end
        prev_req <= mem_req;
        if (c0_done && c1_done) checkOutput("both_done", 1, 0);
        if (err && !(c0_done || c1_done)) checkOutput("stray_err", 1, 0);
        if (c0_done || c1_done) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_done", 1, 0);
            end else begin
                mon_t = exp_q.pop_front();
                checkOutput("done_port", c1_done, mon_t.owner);
                checkOutput("done_owner", owner, mon_t.owner);
                checkOutput("done_err", err, mon_t.err);
                checkOutput("done_rd_blk", rd_blk, mon_t.exp_rd);
            end
        end
    end

    // Memory model: acks on the queued BUSY cycle, measures mem_req length, injects late acks.
    initial begin
        mem_ack    = 1'b0;
        mem_rd_blk = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            if (mem_req) begin
                req_cycles++;
                if (exp_q.size() > 0 && exp_q[0].ack_at == req_cycles) begin
                    mem_ack    = 1'b1;
                    mem_rd_blk = exp_q[0].rd_data;
                end
            end else begin
                if (req_cycles > 0 && exp_q.size() > 0) checkOutput("req_cycles", req_cycles, exp_q[0].req_len);
                req_cycles = 0;
                if (late_ack_done < late_ack_req) begin
                    mem_ack    = 1'b1;
                    mem_rd_blk = fill(8'hFF);
                    late_ack_done++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        c0_req = 1'b0; c0_we = 1'b0; c0_addr = '0; c0_wr_blk = '0;
        c1_req = 1'b0; c1_we = 1'b0; c1_addr = '0; c1_wr_blk = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_mem_req", mem_req, 0);
        checkOutput("rst_owner", owner, 1);
        checkOutput("rst_done", {c0_done, c1_done, err}, 3'b000);
        checkOutput("rst_rd_blk", rd_blk, '0);
        checkOutput("rst_mem_fields", {mem_we, mem_addr}, '0);
        rst = 1'b0;

        $display("[TB] c0 refill, ack on third BUSY cycle");
        applyStimulus(1'b0, 1'b0, 32'h0000_1040, '0, fill(8'hA5), 3);
        @(negedge clk);
        checkOutput("t1_latency", {busy, mem_req}, 2'b11);
        waitDone("t1");
        c0_req = 1'b0;
        checkOutput("t1_rd_blk", rd_blk, fill(8'hA5));

        $display("[TB] simultaneous requests after reset alternate");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        push_expect(1'b0, 1'b0, 32'h0000_3000, '0, fill(8'h11), 1);
        push_expect(1'b1, 1'b0, 32'h0000_4000, '0, fill(8'h22), 1);
        push_expect(1'b0, 1'b0, 32'h0000_3000, '0, fill(8'h33), 1);
        push_expect(1'b1, 1'b0, 32'h0000_4000, '0, fill(8'h44), 1);
        c0_we = 1'b0; c0_addr = 32'h0000_3000; c0_wr_blk = '0;
        c1_we = 1'b0; c1_addr = 32'h0000_4000; c1_wr_blk = '0;
        c0_req = 1'b1; c1_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            waitDone("t2");
            if (i < 3) begin
                @(negedge clk);
                checkOutput("t2_b2b_grant", mem_req, 1);
            end
        end
        c0_req = 1'b0; c1_req = 1'b0;

        $display("[TB] c1 writeback leaves rd_blk alone");
        applyStimulus(1'b1, 1'b1, 32'h0000_2000, fill(8'h5A), fill(8'hDE), 2);
        waitDone("t3");
        c1_req = 1'b0;
        checkOutput("t3_rd_blk", rd_blk, fill(8'h44));

        $display("[TB] timeout then late ack");
        applyStimulus(1'b0, 1'b0, 32'h0000_5000, '0, fill(8'h77), 0);
        waitDone("t4");
        c0_req = 1'b0;
        late_ack_req++;
        repeat (4) @(negedge clk);
        checkOutput("t4_late_rd_blk", rd_blk, fill(8'h44));
        checkOutput("t4_late_busy", busy, 0);

        $display("[TB] ack on the last allowed cycle wins over timeout");
        applyStimulus(1'b1, 1'b0, 32'h0000_6000, '0, fill(8'h66), TO_CYCLES);
        waitDone("t4b");
        c1_req = 1'b0;

        $display("[TB] reset during BUSY");
        c0_we = 1'b0; c0_addr = 32'h0000_7000; c0_wr_blk = '0; c0_req = 1'b1;
        @(negedge clk);
        checkOutput("t5_busy_before", busy, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("t5_after_rst", {mem_req, busy, owner}, 3'b001);
        checkOutput("t5_no_done", {c0_done, c1_done}, 2'b00);
        push_expect(1'b0, 1'b0, 32'h0000_7000, '0, fill(8'h99), 1);
        rst = 1'b0;
        waitDone("t5_rearb");
        c0_req = 1'b0;

        $display("[TB] requester drops req mid-transaction");
        applyStimulus(1'b0, 1'b0, 32'h0000_8000, '0, fill(8'hC3), 3);
        @(negedge clk);
        c0_req = 1'b0;
        waitDone("t6");
        repeat (3) begin
            @(negedge clk);
            checkOutput("t6_stays_idle", {busy, mem_req}, 2'b00);
        end

        checkOutput("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
